// File: rtl/check_scanner_pkg.sv
// Shared constants, types and helpers for the attack scanner.
// Piece index map, FSM states, ray direction table, colour encoding.
package check_scanner_pkg;

   localparam int unsigned KING_ID   = 0;
   localparam int unsigned QUEEN_ID  = 1;
   localparam int unsigned KNIGHT_LO = 4;
   localparam int unsigned ROOK_LO   = 6;
   localparam int unsigned PAWN_LO   = 8;
   localparam int unsigned N_DIRS    = 8;

   localparam logic COLOUR_WHITE = 1'b1;
   localparam logic COLOUR_BLACK = 1'b0;

   typedef enum logic [2:0] {
      PK_KING, PK_QUEEN, PK_BISHOP, PK_KNIGHT, PK_ROOK, PK_PAWN
   } piece_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_RAY, ST_LEAP, ST_DONE
   } state_e;

   // Directions in scan order N, S, E, W, NE, NW, SE, SW; N is increasing row.
   function automatic logic signed [1:0] dir_dr(input logic [2:0] d);
      case (d)
         3'd0, 3'd4, 3'd5: return 2'sb01;
         3'd1, 3'd6, 3'd7: return 2'sb11;
         default:          return 2'sb00;
      endcase
   endfunction

   function automatic logic signed [1:0] dir_dc(input logic [2:0] d);
      case (d)
         3'd2, 3'd4, 3'd6: return 2'sb01;
         3'd3, 3'd5, 3'd7: return 2'sb11;
         default:          return 2'sb00;
      endcase
   endfunction

   function automatic piece_kind_e piece_kind(input int unsigned id);
      if (id == KING_ID)       return PK_KING;
      else if (id == QUEEN_ID) return PK_QUEEN;
      else if (id < KNIGHT_LO) return PK_BISHOP;
      else if (id < ROOK_LO)   return PK_KNIGHT;
      else if (id < PAWN_LO)   return PK_ROOK;
      else                     return PK_PAWN;
   endfunction

endpackage

// File: rtl/check_scanner_if.sv
// Request/result bundle between a requester and the attack scanner.
interface check_scanner_if #(
   parameter int unsigned N_PIECES = 16,
   parameter int unsigned COORD_W  = 3
);
   logic                            start;
   logic                            player;
   logic                            use_target;
   logic [COORD_W-1:0]              target_row;
   logic [COORD_W-1:0]              target_col;
   logic [2*COORD_W*N_PIECES-1:0]   locationVectorWhite;
   logic [2*COORD_W*N_PIECES-1:0]   locationVectorBlack;
   logic [N_PIECES-1:0]             aliveVectorWhite;
   logic [N_PIECES-1:0]             aliveVectorBlack;
   logic                            busy;
   logic                            done;
   logic [N_PIECES-1:0]             attackers;
   logic                            in_check;

   modport master (
      output start, player, use_target, target_row, target_col,
             locationVectorWhite, locationVectorBlack, aliveVectorWhite, aliveVectorBlack,
      input  busy, done, attackers, in_check
   );

   modport slave (
      input  start, player, use_target, target_row, target_col,
             locationVectorWhite, locationVectorBlack, aliveVectorWhite, aliveVectorBlack,
      output busy, done, attackers, in_check
   );
endinterface

// File: rtl/check_scanner_board_map.sv
// Registered square->piece map, rebuilt from scratch when load is high.
// Pieces are written white then black, ascending index, so a later write owns a shared square.
module check_board_map
   import check_scanner_pkg::*;
#(
   parameter int unsigned N_PIECES = 16,
   parameter int unsigned COORD_W  = 3,
   localparam int unsigned ID_W  = $clog2(N_PIECES),
   localparam int unsigned ENT_W = ID_W + 2,
   localparam int unsigned SQ_W  = 2 * COORD_W,
   localparam int unsigned B_SQ  = 1 << SQ_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load,
   input  logic [SQ_W*N_PIECES-1:0] loc_w,
   input  logic [SQ_W*N_PIECES-1:0] loc_b,
   input  logic [N_PIECES-1:0]      alive_w,
   input  logic [N_PIECES-1:0]      alive_b,
   output logic [ENT_W-1:0]         board [B_SQ]
);

   logic [ENT_W-1:0] board_q [B_SQ];
   logic [ENT_W-1:0] board_d [B_SQ];

   always_comb begin
      board_d = board_q;
      if (load) begin
         for (int s = 0; s < int'(B_SQ); s++) board_d[s] = '0;
         for (int i = 0; i < int'(N_PIECES); i++)
            if (alive_w[i]) board_d[loc_w[i*SQ_W +: SQ_W]] = {1'b1, COLOUR_WHITE, ID_W'(i)};
         for (int i = 0; i < int'(N_PIECES); i++)
            if (alive_b[i]) board_d[loc_b[i*SQ_W +: SQ_W]] = {1'b1, COLOUR_BLACK, ID_W'(i)};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < int'(B_SQ); s++) board_q[s] <= '0;
      end else begin
         board_q <= board_d;
      end
   end

   assign board = board_q;

endmodule

// File: rtl/check_scanner.sv
// Multi-cycle attack scanner: rays for sliders, then a per-piece leap pass
// for knights, king and pawns; fixed-latency start/done handshake.
module check_scanner
   import check_scanner_pkg::*;
#(
   parameter int unsigned N_PIECES = 16,
   parameter int unsigned COORD_W  = 3,
   parameter bit          WHITE_UP = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   check_scanner_if.slave bus
);

   localparam int unsigned ID_W  = $clog2(N_PIECES);
   localparam int unsigned ENT_W = ID_W + 2;
   localparam int unsigned SQ_W  = 2 * COORD_W;
   localparam int unsigned B_SQ  = 1 << SQ_W;
   localparam int unsigned SC_W  = COORD_W + 1;
   localparam int unsigned LOC_W = SQ_W * N_PIECES;
   localparam int unsigned LAST_STEP = (1 << COORD_W) - 2;

   state_e                  state_q, state_d;
   logic                    player_q, player_d;
   logic [COORD_W-1:0]      tgt_r_q, tgt_r_d, tgt_c_q, tgt_c_d;
   logic                    no_tgt_q, no_tgt_d;
   logic [LOC_W-1:0]        loc_w_q, loc_w_d, loc_b_q, loc_b_d;
   logic [N_PIECES-1:0]     alive_w_q, alive_w_d, alive_b_q, alive_b_d;
   logic [2:0]              dir_q, dir_d;
   logic [COORD_W-1:0]      step_q, step_d;
   logic                    stop_q, stop_d;
   logic signed [SC_W-1:0]  cur_r_q, cur_r_d, cur_c_q, cur_c_d;
   logic [ID_W-1:0]         leap_q, leap_d;
   logic [N_PIECES-1:0]     acc_q, acc_d, attackers_q, attackers_d;
   logic                    busy_q, busy_d, done_q, done_d, in_check_q, in_check_d;
   logic                    board_load_c;

   logic [ENT_W-1:0] board [B_SQ];

   check_board_map #(.N_PIECES(N_PIECES), .COORD_W(COORD_W)) u_board (
      .clock(clock), .reset(reset), .load(board_load_c),
      .loc_w(loc_w_q), .loc_b(loc_b_q), .alive_w(alive_w_q), .alive_b(alive_b_q),
      .board(board)
   );

   // Ray step: next square along the current direction and what sits there.
   logic signed [SC_W-1:0] nxt_r_c, nxt_c_c;
   logic                   on_board_c;
   logic [ENT_W-1:0]       ent_c;
   logic [ID_W-1:0]        ent_id_c;
   logic                   ent_occ_c, ent_col_c, ray_pass_c, ray_hit_c;
   piece_kind_e            ray_kind_c;

   assign nxt_r_c    = cur_r_q + SC_W'(dir_dr(dir_q));
   assign nxt_c_c    = cur_c_q + SC_W'(dir_dc(dir_q));
   assign on_board_c = !nxt_r_c[SC_W-1] && !nxt_c_c[SC_W-1];
   assign ent_c      = board[{nxt_r_c[COORD_W-1:0], nxt_c_c[COORD_W-1:0]}];
   assign ent_occ_c  = ent_c[ENT_W-1];
   assign ent_col_c  = ent_c[ENT_W-2];
   assign ent_id_c   = ent_c[ID_W-1:0];
   assign ray_kind_c = piece_kind(32'(ent_id_c));
   // The own king never blocks a ray: it is either the target or looks through to it.
   assign ray_pass_c = !ent_occ_c || (ent_col_c == player_q && ent_id_c == ID_W'(KING_ID));
   assign ray_hit_c  = (ent_col_c != player_q) &&
                       (ray_kind_c == PK_QUEEN ||
                        (ray_kind_c == PK_ROOK   && dir_q <  3'd4) ||
                        (ray_kind_c == PK_BISHOP && dir_q >= 3'd4));

   // Leap pass: offset from opponent piece leap_q to the target.
   logic [LOC_W-1:0]       opp_loc_c;
   logic [N_PIECES-1:0]    opp_alive_c;
   logic [SQ_W-1:0]        lp_sq_c, own_king_c;
   logic signed [SC_W-1:0] ldr_c, ldc_c, pawn_fwd_c;
   logic [COORD_W-1:0]     adr_c, adc_c;
   logic                   leap_hit_c;

   assign opp_loc_c   = player_q ? loc_b_q : loc_w_q;
   assign opp_alive_c = player_q ? alive_b_q : alive_w_q;
   assign lp_sq_c     = opp_loc_c[32'(leap_q)*SQ_W +: SQ_W];
   assign ldr_c       = $signed({1'b0, tgt_r_q}) - $signed({1'b0, lp_sq_c[SQ_W-1:COORD_W]});
   assign ldc_c       = $signed({1'b0, tgt_c_q}) - $signed({1'b0, lp_sq_c[COORD_W-1:0]});
   assign adr_c       = ldr_c[SC_W-1] ? COORD_W'(-ldr_c) : COORD_W'(ldr_c);
   assign adc_c       = ldc_c[SC_W-1] ? COORD_W'(-ldc_c) : COORD_W'(ldc_c);
   assign pawn_fwd_c  = (player_q ^ WHITE_UP) ? SC_W'(1) : -SC_W'(1);
   assign own_king_c  = bus.player ? bus.locationVectorWhite[SQ_W-1:0]
                                   : bus.locationVectorBlack[SQ_W-1:0];

   always_comb begin
      leap_hit_c = 1'b0;
      case (piece_kind(32'(leap_q)))
         PK_KNIGHT: leap_hit_c = (adr_c == COORD_W'(1) && adc_c == COORD_W'(2)) ||
                                 (adr_c == COORD_W'(2) && adc_c == COORD_W'(1));
         PK_KING:   leap_hit_c = adr_c <= COORD_W'(1) && adc_c <= COORD_W'(1) &&
                                 (adr_c | adc_c) != '0;
         PK_PAWN:   leap_hit_c = adc_c == COORD_W'(1) && ldr_c == pawn_fwd_c;
         default:   leap_hit_c = 1'b0;
      endcase
      leap_hit_c = leap_hit_c && opp_alive_c[leap_q];
   end

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;     player_d = player_q;   tgt_r_d = tgt_r_q;   tgt_c_d = tgt_c_q;
      no_tgt_d = no_tgt_q;   loc_w_d = loc_w_q;     loc_b_d = loc_b_q;
      alive_w_d = alive_w_q; alive_b_d = alive_b_q; dir_d = dir_q;       step_d = step_q;
      stop_d = stop_q;       cur_r_d = cur_r_q;     cur_c_d = cur_c_q;   leap_d = leap_q;
      acc_d = acc_q;         attackers_d = attackers_q;                  in_check_d = in_check_q;
      busy_d = busy_q;       done_d = 1'b0;         board_load_c = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.start) begin
            player_d  = bus.player;
            loc_w_d   = bus.locationVectorWhite;  loc_b_d   = bus.locationVectorBlack;
            alive_w_d = bus.aliveVectorWhite;     alive_b_d = bus.aliveVectorBlack;
            if (bus.use_target) begin
               tgt_r_d = bus.target_row;  tgt_c_d = bus.target_col;  no_tgt_d = 1'b0;
            end else begin
               tgt_r_d  = own_king_c[SQ_W-1:COORD_W];
               tgt_c_d  = own_king_c[COORD_W-1:0];
               no_tgt_d = !(bus.player ? bus.aliveVectorWhite[0] : bus.aliveVectorBlack[0]);
            end
            acc_d = '0;  attackers_d = '0;  in_check_d = 1'b0;
            busy_d = 1'b1;  state_d = ST_LOAD;
         end
         ST_LOAD: begin
            board_load_c = 1'b1;
            dir_d = '0;  step_d = '0;  stop_d = 1'b0;
            cur_r_d = SC_W'(tgt_r_q);  cur_c_d = SC_W'(tgt_c_q);
            state_d = ST_RAY;
         end
         ST_RAY: begin
            if (!stop_q && !no_tgt_q) begin
               if (!on_board_c) begin
                  stop_d = 1'b1;
               end else if (ray_pass_c) begin
                  cur_r_d = nxt_r_c;  cur_c_d = nxt_c_c;
               end else begin
                  stop_d = 1'b1;
                  if (ray_hit_c) acc_d[ent_id_c] = 1'b1;
               end
            end
            if (step_q == COORD_W'(LAST_STEP)) begin
               step_d = '0;  stop_d = 1'b0;  dir_d = dir_q + 3'd1;
               cur_r_d = SC_W'(tgt_r_q);  cur_c_d = SC_W'(tgt_c_q);
               if (dir_q == 3'(N_DIRS - 1)) begin
                  leap_d = '0;  state_d = ST_LEAP;
               end
            end else begin
               step_d = step_q + COORD_W'(1);
            end
         end
         ST_LEAP: begin
            if (!no_tgt_q && leap_hit_c) acc_d[leap_q] = 1'b1;
            if (leap_q == ID_W'(N_PIECES - 1)) begin
               attackers_d = acc_d;  in_check_d = |acc_d;
               done_d = 1'b1;  state_d = ST_DONE;
            end else begin
               leap_d = leap_q + ID_W'(1);
            end
         end
         ST_DONE: begin
            busy_d = 1'b0;  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;  player_q <= 1'b0;  tgt_r_q <= '0;  tgt_c_q <= '0;
         no_tgt_q <= 1'b0;    loc_w_q <= '0;     loc_b_q <= '0;
         alive_w_q <= '0;     alive_b_q <= '0;   dir_q <= '0;    step_q <= '0;
         stop_q <= 1'b0;      cur_r_q <= '0;     cur_c_q <= '0;  leap_q <= '0;
         acc_q <= '0;         attackers_q <= '0; in_check_q <= 1'b0;
         busy_q <= 1'b0;      done_q <= 1'b0;
      end else begin
         state_q <= state_d;  player_q <= player_d;  tgt_r_q <= tgt_r_d;  tgt_c_q <= tgt_c_d;
         no_tgt_q <= no_tgt_d;  loc_w_q <= loc_w_d;  loc_b_q <= loc_b_d;
         alive_w_q <= alive_w_d;  alive_b_q <= alive_b_d;  dir_q <= dir_d;  step_q <= step_d;
         stop_q <= stop_d;    cur_r_q <= cur_r_d;    cur_c_q <= cur_c_d;  leap_q <= leap_d;
         acc_q <= acc_d;      attackers_q <= attackers_d;  in_check_q <= in_check_d;
         busy_q <= busy_d;    done_q <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.attackers = attackers_q;
   assign bus.in_check  = in_check_q;

endmodule
